fir_dac_tx: RTL and testbench
=============================

Name: fir_dac_tx

Overview:
- Serial transmitter for the output end of the time-multiplexed FIR datapath.
- Captures each 16-bit filtered sample on the sample strobe that paces the filter and shifts it out MSB-first to an external serial DAC.
- Outputs are a bit clock, a frame sync and a data line.
- Uses a single-entry holding buffer, so the next sample can be captured while the current frame is on the wire.

Parameters:
WIDTH, 16, sample word width in bits; equals the shift length per frame.
DIV, 1, sclk half-period in clk cycles (min 1); one bit period = 2*DIV clk cycles.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
sample  input  1  one-clk sample strobe, the same strobe that advances the FIR delay line
dIn  input  WIDTH  filter output word (two's complement), captured when sample=1
sclk  output  1  serial bit clock to DAC, registered
sdata  output  1  serial data, MSB first, registered; changes only while sclk=0
sync  output  1  frame sync, registered; high for the whole first bit (MSB) of each frame
busy  output  1  high while a frame is being shifted
overrun  output  1  one-clk pulse: sample arrived while the holding buffer was still full

Behaviour:
- Reset:
  - Applies on the clk edge where reset=1, with priority over every other event.
  - Result: sclk=0, sdata=0, sync=0, busy=0, overrun=0; hold_full=0; state IDLE; all counters 0.
  - Reset mid-frame aborts the frame; the next frame starts only after a new sample.
- Capture:
  - On an edge with sample=1, dIn goes to the hold register and hold_full is set.
  - If hold_full was already 1 and not being drained on that same edge: hold is overwritten (newest wins) and overrun pulses high for the next cycle.
- States: IDLE, SHIFT.
- IDLE:
  - Outputs: sclk=0, sync=0, busy=0, sdata=0.
  - If hold_full=1: load hold into the shift register, clear hold_full, set bit_cnt=WIDTH-1 and phase=0, then go to SHIFT.
  - If sample=1 on that same edge: the new word enters hold, hold_full stays 1, and no overrun pulses.
- SHIFT:
  - phase counts 0..2*DIV-1 in clk cycles.
  - sclk is 0 for phase 0..DIV-1 and 1 for phase DIV..2*DIV-1.
  - sdata = shift register MSB.
  - sync = 1 while bit_cnt=WIDTH-1.
  - busy = 1.
- End of bit (phase=2*DIV-1):
  - phase returns to 0.
  - If bit_cnt>0: shift left by one and decrement bit_cnt.
  - If bit_cnt=0 and hold_full=1: reload directly from hold (back-to-back frame, no IDLE cycle) and stay in SHIFT.
  - If bit_cnt=0 and hold_full=0: go to IDLE.
- Latency:
  - sample at edge T sets hold_full at T.
  - From IDLE, the load happens at edge T+1.
  - First SHIFT cycle (sync=1, sdata=MSB, sclk=0) is the cycle after edge T+1.
- Frame length: WIDTH*2*DIV clk cycles. Isolated frames also incur one IDLE load cycle.
- Rate constraint: the sample period must be >= WIDTH*2*DIV+1 clocks for zero overruns. With the defaults this is 33, which the 32-tap FIR already guarantees.
- Output timing: all outputs come from registers with no combinational path from inputs. The receiver samples sdata on the sclk rising edge.

Test Plan:
- DIV=1: reset, then sample with dIn=16'hA5C3, no further samples.
  - Required: 32 busy cycles; sdata bit sequence 1010010111000011.
  - sync high for the first 2 clocks only; sclk pattern 0,1 repeated 16 times.
  - Then IDLE with all outputs 0.
- DIV=2, dIn=16'h8001:
  - sclk low 2 / high 2 clocks per bit.
  - sdata=1 for the first 4 clocks, 0 for the next 56, 1 for the last 4; busy for 64 clocks.
- Back-to-back, DIV=1: samples 16'h1234 and 16'hFFFF 20 clocks apart.
  - Required: the second frame starts with no gap right after bit 0 of the first.
  - sync high again for 2 clocks; no overrun.
- Overrun: during frame 16'h0F0F, samples 16'h1111 then 16'h2222, 5 clocks apart.
  - Required: overrun pulses once, 1 clock after the 16'h2222 strobe.
  - The next frame transmits 16'h2222.
- Reset at clock 10 of an active frame.
  - Required: next cycle sclk=sdata=sync=busy=0.
  - A pending hold word is discarded; no output until a new sample.
- Simultaneous sample and load in IDLE: hold_full=1 with 16'hAAAA, sample with 16'h5555 on the load edge.
  - Required: 16'hAAAA frame, then 16'h5555 frame back-to-back; overrun stays 0.

Source files
------------

// File: rtl/fir_dac_tx_if.sv
// Sample/serial bus between the FIR output stage and the DAC transmitter.
interface fir_dac_tx_if #(
    parameter int unsigned WIDTH = 16
);
    logic             sample;
    logic [WIDTH-1:0] dIn;
    logic             sclk;
    logic             sdata;
    logic             sync;
    logic             busy;
    logic             overrun;

    modport master (
        output sample,
        output dIn,
        input  sclk,
        input  sdata,
        input  sync,
        input  busy,
        input  overrun
    );

    modport slave (
        input  sample,
        input  dIn,
        output sclk,
        output sdata,
        output sync,
        output busy,
        output overrun
    );
endinterface

// File: rtl/fir_dac_tx.sv
// Serial DAC transmitter: captures FIR output words into a one-entry hold
// buffer and shifts them out MSB-first with bit clock and frame sync.
module fir_dac_tx #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIV   = 1
) (
    input  logic        clk,
    input  logic        reset,
    fir_dac_tx_if.slave bus
);
    localparam int unsigned   PW      = $clog2(2 * DIV);
    localparam int unsigned   CW      = $clog2(WIDTH);
    localparam logic [PW-1:0] PH_LAST = PW'(2 * DIV - 1);
    localparam logic [PW-1:0] PH_HIGH = PW'(DIV);
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state,     state_n;
    logic [PW-1:0]     phase,     phase_n;
    logic [CW-1:0]     bit_cnt,   bit_cnt_n;
    logic [WIDTH-1:0]  shreg,     shreg_n;
    logic [WIDTH-1:0]  hold,      hold_n;
    logic              hold_full, hold_full_n;
    logic              drain;
    logic              shifting_n;
    logic              sclk_q,    sclk_n;
    logic              sdata_q,   sdata_n;
    logic              sync_q,    sync_n;
    logic              busy_q,    busy_n;
    logic              overrun_q, overrun_n;

    // State, datapath and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            sync_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            sclk_q    <= sclk_n;
            sdata_q   <= sdata_n;
            sync_q    <= sync_n;
            busy_q    <= busy_n;
            overrun_q <= overrun_n;
        end
    end

    // Next-state logic; outputs are derived from next state so the
    // registered pins line up with the cycle they describe.
    always_comb begin
        state_n     = state;
        phase_n     = phase;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        hold_n      = hold;
        hold_full_n = hold_full;
        drain       = 1'b0;

        case (state)
            IDLE: begin
                if (hold_full) begin
                    drain     = 1'b1;
                    shreg_n   = hold;
                    bit_cnt_n = CNT_TOP;
                    phase_n   = '0;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (phase == PH_LAST) begin
                    phase_n = '0;
                    if (bit_cnt != '0) begin
                        shreg_n   = {shreg[WIDTH-2:0], 1'b0};
                        bit_cnt_n = bit_cnt - CW'(1);
                    end else if (hold_full) begin
                        // Back-to-back frame: reload without an IDLE cycle.
                        drain     = 1'b1;
                        shreg_n   = hold;
                        bit_cnt_n = CNT_TOP;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    phase_n = phase + PW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // A new sample always lands in hold; newest word wins.
        if (bus.sample) begin
            hold_n      = bus.dIn;
            hold_full_n = 1'b1;
        end else if (drain) begin
            hold_full_n = 1'b0;
        end

        overrun_n  = bus.sample && hold_full && !drain;
        shifting_n = (state_n == SHIFT);
        sclk_n     = shifting_n && (phase_n >= PH_HIGH);
        sdata_n    = shifting_n && shreg_n[WIDTH-1];
        sync_n     = shifting_n && (bit_cnt_n == CNT_TOP);
        busy_n     = shifting_n;
    end

    assign bus.sclk    = sclk_q;
    assign bus.sdata   = sdata_q;
    assign bus.sync    = sync_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_fir_dac_tx.sv
// Self-checking bench for fir_dac_tx: DIV=1 and DIV=2 instances, scoreboard
// of transmitted words decoded from the serial lines.
module tb_fir_dac_tx;
    logic clk = 1'b0;
    logic reset1, reset2;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ovr1     = 0;

    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic [15:0] rx_word    = '0;
    int          rx_bits    = 0;
    logic        prev_sclk1 = 1'b0;

    fir_dac_tx_if #(.WIDTH(16)) b1();
    fir_dac_tx_if #(.WIDTH(16)) b2();

    fir_dac_tx #(.WIDTH(16), .DIV(1)) dut1 (.clk(clk), .reset(reset1), .bus(b1.slave));
    fir_dac_tx #(.WIDTH(16), .DIV(2)) dut2 (.clk(clk), .reset(reset2), .bus(b2.slave));

    always #5 clk = ~clk;

    // Receiver model for dut1: sample sdata on sclk rising, sync starts a word.
    always @(negedge clk) begin
        if (b1.sclk === 1'b1 && prev_sclk1 === 1'b0) begin
            if (b1.sync === 1'b1) begin
                rx_word = {15'b0, b1.sdata};
                rx_bits = 1;
            end else begin
                rx_word = {rx_word[14:0], b1.sdata};
                rx_bits++;
            end
            if (rx_bits == 16) begin
                got_q.push_back(rx_word);
                rx_bits = 0;
            end
        end
        prev_sclk1 = b1.sclk;
        if (b1.overrun === 1'b1) ovr1++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each word bit repeated rep times, first bit in the most significant used slot.
    function automatic logic [63:0] expand(input logic [15:0] w, input int rep);
        logic [63:0] r;
        r = '0;
        for (int b = 15; b >= 0; b--)
            for (int k = 0; k < rep; k++)
                r = {r[62:0], w[b]};
        return r;
    endfunction

    task automatic test_reset();
        reset1 = 1'b1; reset2 = 1'b1;
        b1.sample = 1'b0; b1.dIn = '0;
        b2.sample = 1'b0; b2.dIn = '0;
        tick(); tick();
        reset1 = 1'b0; reset2 = 1'b0;
        n_checks++;
        if ({b1.sclk, b1.sdata, b1.sync, b1.busy, b1.overrun} !== 5'b0)
            $display("FAIL reset_div1: outputs=%b expected 00000",
                     {b1.sclk, b1.sdata, b1.sync, b1.busy, b1.overrun});
        else n_pass++;
        n_checks++;
        if ({b2.sclk, b2.sdata, b2.sync, b2.busy, b2.overrun} !== 5'b0)
            $display("FAIL reset_div2: outputs=%b expected 00000",
                     {b2.sclk, b2.sdata, b2.sync, b2.busy, b2.overrun});
        else n_pass++;
        tick();
    endtask

    task automatic test_single_frame();
        logic [31:0] t_sclk, t_sync, t_busy, t_sdata;
        logic [63:0] e;
        logic [15:0] g, x;
        int ovr0;
        ovr0 = ovr1;
        b1.sample = 1'b1; b1.dIn = 16'hA5C3; exp_q.push_back(16'hA5C3);
        tick();
        b1.sample = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            t_sclk = {t_sclk[30:0], b1.sclk};
            t_sync = {t_sync[30:0], b1.sync};
            t_busy = {t_busy[30:0], b1.busy};
            t_sdata = {t_sdata[30:0], b1.sdata};
        end
        e = expand(16'hA5C3, 2);
        n_checks++;
        if (t_sdata !== e[31:0]) $display("FAIL single_sdata: got %h expected %h", t_sdata, e[31:0]);
        else n_pass++;
        n_checks++;
        if (t_sclk !== 32'h5555_5555) $display("FAIL single_sclk: got %h expected 55555555", t_sclk);
        else n_pass++;
        n_checks++;
        if (t_sync !== 32'hC000_0000) $display("FAIL single_sync: got %h expected c0000000", t_sync);
        else n_pass++;
        n_checks++;
        if (t_busy !== 32'hFFFF_FFFF) $display("FAIL single_busy: got %h expected ffffffff", t_busy);
        else n_pass++;
        tick();
        n_checks++;
        if ({b1.sclk, b1.sdata, b1.sync, b1.busy, b1.overrun} !== 5'b0)
            $display("FAIL single_idle: outputs=%b expected 00000",
                     {b1.sclk, b1.sdata, b1.sync, b1.busy, b1.overrun});
        else n_pass++;
        n_checks++;
        if (got_q.size() == 0 || exp_q.size() == 0) begin
            $display("FAIL single_sb: got_q=%0d exp_q=%0d entries", got_q.size(), exp_q.size());
        end else begin
            g = got_q.pop_front(); x = exp_q.pop_front();
            if (g !== x) $display("FAIL single_sb: got %h expected %h", g, x);
            else n_pass++;
        end
        n_checks++;
        if (ovr1 !== ovr0) $display("FAIL single_overrun: pulses %0d expected 0", ovr1 - ovr0);
        else n_pass++;
    endtask

    task automatic test_div2();
        logic [63:0] t_sclk, t_sync, t_busy, t_sdata, e;
        b2.sample = 1'b1; b2.dIn = 16'h8001;
        tick();
        b2.sample = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            t_sclk = {t_sclk[62:0], b2.sclk};
            t_sync = {t_sync[62:0], b2.sync};
            t_busy = {t_busy[62:0], b2.busy};
            t_sdata = {t_sdata[62:0], b2.sdata};
        end
        e = expand(16'h8001, 4);
        n_checks++;
        if (t_sdata !== e) $display("FAIL div2_sdata: got %h expected %h", t_sdata, e);
        else n_pass++;
        n_checks++;
        if (t_sclk !== 64'h3333_3333_3333_3333) $display("FAIL div2_sclk: got %h expected 3333333333333333", t_sclk);
        else n_pass++;
        n_checks++;
        if (t_sync !== 64'hF000_0000_0000_0000) $display("FAIL div2_sync: got %h expected f000000000000000", t_sync);
        else n_pass++;
        n_checks++;
        if (t_busy !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL div2_busy: got %h expected all ones", t_busy);
        else n_pass++;
        tick();
        n_checks++;
        if (b2.busy !== 1'b0) $display("FAIL div2_idle: busy=%b expected 0", b2.busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] t_sync, t_busy, t_sdata, e;
        logic [15:0] g, x;
        int ovr0;
        ovr0 = ovr1;
        b1.sample = 1'b1; b1.dIn = 16'h1234; exp_q.push_back(16'h1234);
        tick();
        for (int i = 0; i < 64; i++) begin
            b1.sample = (i == 19);
            b1.dIn = 16'hFFFF;
            if (i == 19) exp_q.push_back(16'hFFFF);
            tick();
            t_sync = {t_sync[62:0], b1.sync};
            t_busy = {t_busy[62:0], b1.busy};
            t_sdata = {t_sdata[62:0], b1.sdata};
        end
        b1.sample = 1'b0;
        e = {expand(16'h1234, 2)[31:0], expand(16'hFFFF, 2)[31:0]};
        n_checks++;
        if (t_sdata !== e) $display("FAIL b2b_sdata: got %h expected %h", t_sdata, e);
        else n_pass++;
        n_checks++;
        if (t_busy !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL b2b_busy_gap: got %h expected all ones", t_busy);
        else n_pass++;
        n_checks++;
        if (t_sync !== 64'hC000_0000_C000_0000) $display("FAIL b2b_sync: got %h expected c0000000c0000000", t_sync);
        else n_pass++;
        tick();
        n_checks++;
        if (ovr1 !== ovr0) $display("FAIL b2b_overrun: pulses %0d expected 0", ovr1 - ovr0);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                $display("FAIL b2b_sb%0d: got_q=%0d exp_q=%0d entries", k, got_q.size(), exp_q.size());
            end else begin
                g = got_q.pop_front(); x = exp_q.pop_front();
                if (g !== x) $display("FAIL b2b_sb%0d: got %h expected %h", k, g, x);
                else n_pass++;
            end
        end
    endtask

    task automatic test_overrun();
        logic [63:0] t_ovr, t_sdata, e;
        logic [15:0] g, x;
        b1.sample = 1'b1; b1.dIn = 16'h0F0F; exp_q.push_back(16'h0F0F);
        tick();
        for (int i = 0; i < 64; i++) begin
            b1.sample = (i == 3) || (i == 8);
            b1.dIn = (i == 3) ? 16'h1111 : 16'h2222;
            if (i == 3) exp_q.push_back(16'h1111);
            if (i == 8) exp_q[exp_q.size() - 1] = 16'h2222;
            tick();
            t_ovr = {t_ovr[62:0], b1.overrun};
            t_sdata = {t_sdata[62:0], b1.sdata};
        end
        b1.sample = 1'b0;
        n_checks++;
        if (t_ovr !== (64'd1 << 55)) $display("FAIL ovr_pulse: got %h expected %h", t_ovr, 64'd1 << 55);
        else n_pass++;
        e = {expand(16'h0F0F, 2)[31:0], expand(16'h2222, 2)[31:0]};
        n_checks++;
        if (t_sdata !== e) $display("FAIL ovr_sdata: got %h expected %h", t_sdata, e);
        else n_pass++;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                $display("FAIL ovr_sb%0d: got_q=%0d exp_q=%0d entries", k, got_q.size(), exp_q.size());
            end else begin
                g = got_q.pop_front(); x = exp_q.pop_front();
                if (g !== x) $display("FAIL ovr_sb%0d: got %h expected %h", k, g, x);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic busy_seen;
        b1.sample = 1'b1; b1.dIn = 16'h4321;
        tick();
        for (int i = 0; i <= 10; i++) begin
            b1.sample = (i == 2);
            b1.dIn = 16'h7777;
            reset1 = (i == 10);
            tick();
        end
        b1.sample = 1'b0; reset1 = 1'b0;
        n_checks++;
        if ({b1.sclk, b1.sdata, b1.sync, b1.busy, b1.overrun} !== 5'b0)
            $display("FAIL midreset_outputs: outputs=%b expected 00000",
                     {b1.sclk, b1.sdata, b1.sync, b1.busy, b1.overrun});
        else n_pass++;
        busy_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            busy_seen = busy_seen | b1.busy;
        end
        n_checks++;
        if (busy_seen !== 1'b0) $display("FAIL midreset_hold_discard: busy=%b expected 0", busy_seen);
        else n_pass++;
        n_checks++;
        if (got_q.size() != 0) $display("FAIL midreset_no_word: got_q=%0d expected 0", got_q.size());
        else n_pass++;
    endtask

    task automatic test_simul_load();
        logic [63:0] t_busy, t_sdata, e;
        logic [15:0] g, x;
        int ovr0;
        ovr0 = ovr1;
        b1.sample = 1'b1; b1.dIn = 16'hAAAA; exp_q.push_back(16'hAAAA);
        tick();
        for (int i = 0; i < 64; i++) begin
            b1.sample = (i == 0);
            b1.dIn = 16'h5555;
            if (i == 0) exp_q.push_back(16'h5555);
            tick();
            t_busy = {t_busy[62:0], b1.busy};
            t_sdata = {t_sdata[62:0], b1.sdata};
        end
        b1.sample = 1'b0;
        e = {expand(16'hAAAA, 2)[31:0], expand(16'h5555, 2)[31:0]};
        n_checks++;
        if (t_sdata !== e) $display("FAIL simul_sdata: got %h expected %h", t_sdata, e);
        else n_pass++;
        n_checks++;
        if (t_busy !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL simul_busy: got %h expected all ones", t_busy);
        else n_pass++;
        tick();
        n_checks++;
        if (ovr1 !== ovr0) $display("FAIL simul_overrun: pulses %0d expected 0", ovr1 - ovr0);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                $display("FAIL simul_sb%0d: got_q=%0d exp_q=%0d entries", k, got_q.size(), exp_q.size());
            end else begin
                g = got_q.pop_front(); x = exp_q.pop_front();
                if (g !== x) $display("FAIL simul_sb%0d: got %h expected %h", k, g, x);
                else n_pass++;
            end
        end
        n_checks++;
        if (exp_q.size() != 0 || got_q.size() != 0)
            $display("FAIL sb_drained: exp_q=%0d got_q=%0d expected 0 0", exp_q.size(), got_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_div2();
        test_back_to_back();
        test_overrun();
        test_reset_mid_frame();
        test_simul_load();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
